// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO output buffer.
// The optional drop counter is enabled by defining GPIO_OVF_COUNT_EN.
package gpio_pkg;

    localparam int GPIO_DATA_W = 8;
    localparam int GPIO_DEPTH  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } gpio_buf_state_t;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int gpio_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gpio_fifo.sv
// Circular byte store behind the output slot; ENTRIES may be as small as 1.
module gpio_fifo #(
    parameter int DATA_W  = 8,
    parameter int ENTRIES = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);
    // A single-entry store still needs a one-bit pointer.
    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(ENTRIES + 1);

    logic [DATA_W-1:0] mem [ENTRIES];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(ENTRIES));

endmodule

// File: rtl/gpio_out_buffer.sv
// GPIO store buffer: FIFO plus registered output slot drained over valid/ready.
// Define GPIO_OVF_COUNT_EN to add the saturating ovf_count output.
module gpio_out_buffer
    import gpio_pkg::*;
#(
    parameter int DATA_W = GPIO_DATA_W,
    parameter int DEPTH  = GPIO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          gpio_data,
    input  logic                       gpio_en,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [gpio_level_w(DEPTH)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
`ifdef GPIO_OVF_COUNT_EN
    output logic [7:0]                 ovf_count,
`endif
    input  logic                       ovf_clr
);
    localparam int LVL_W = gpio_level_w(DEPTH);

    gpio_buf_state_t   state_reg;
    logic [DATA_W-1:0] slot_reg;
    logic              valid_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [LVL_W-1:0]  level_next;
    logic              full_reg;
    logic              empty_reg;
    logic              ovf_reg;

    logic              pop;
    logic              push_ok;
    logic              drop;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_full;

    assign pop     = valid_reg && out_ready;
    assign push_ok = gpio_en && (!full_reg || pop);
    assign drop    = gpio_en && full_reg && !pop;

    // While the slot is refilled from an empty FIFO, the push bypasses the FIFO.
    always_comb begin
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (state_reg == HOLD) begin
            if (pop && !fifo_empty) begin
                fifo_pop  = 1'b1;
                fifo_push = push_ok;
            end else if (!pop) begin
                fifo_push = push_ok;
            end
        end
    end

    gpio_fifo #(
        .DATA_W  (DATA_W),
        .ENTRIES (DEPTH - 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (gpio_data),
        .head  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            slot_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (push_ok) begin
                        slot_reg  <= gpio_data;
                        valid_reg <= 1'b1;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (pop) begin
                        if (!fifo_empty) begin
                            slot_reg <= fifo_head;
                        end else if (push_ok) begin
                            slot_reg <= gpio_data;
                        end else begin
                            valid_reg <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        level_next = level_reg;
        if (push_ok && !pop) begin
            level_next = level_reg + 1'b1;
        end else if (pop && !push_ok) begin
            level_next = level_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
            ovf_reg   <= 1'b0;
        end else begin
            level_reg <= level_next;
            full_reg  <= (level_next == LVL_W'(DEPTH));
            empty_reg <= (level_next == '0);
            // A drop wins over a same-cycle clear.
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

`ifdef GPIO_OVF_COUNT_EN
    logic [7:0] ovf_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count_reg <= '0;
        end else if (ovf_clr) begin
            ovf_count_reg <= drop ? 8'd1 : 8'd0;
        end else if (drop && (ovf_count_reg != 8'hFF)) begin
            ovf_count_reg <= ovf_count_reg + 1'b1;
        end
    end

    assign ovf_count = ovf_count_reg;
`endif

    assign out_data  = slot_reg;
    assign out_valid = valid_reg;
    assign level     = level_reg;
    assign full      = full_reg;
    assign empty     = empty_reg;
    assign ovf       = ovf_reg;

    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

endmodule

// File: tb/tb_gpio_out_buffer.sv
// Self-checking bench: queue-based model of the buffer, directed cases then random traffic.
module tb_gpio_out_buffer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] gpio_data = '0;
    logic              gpio_en = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              ovf_clr = 1'b0;
`ifdef GPIO_OVF_COUNT_EN
    logic [7:0]        ovf_count;
`endif

    gpio_out_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .gpio_data (gpio_data),
        .gpio_en   (gpio_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
`ifdef GPIO_OVF_COUNT_EN
        .ovf_count (ovf_count),
`endif
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: every byte currently held, oldest first; q[0] is the presented byte.
    logic [7:0] q[$];
    bit         m_ovf = 0;
    int         m_cnt = 0;
    int         drops = 0;
    logic [7:0] prev_data;
    bit         prev_stall = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_cnt = 0;
        prev_stall = 0;
    endtask

    task automatic compare_all();
        chk("out_valid", int'(out_valid), int'(q.size() > 0));
        if (q.size() > 0) chk("out_data", int'(out_data), int'(q[0]));
        chk("level", int'(level), q.size());
        chk("full", int'(full), int'(q.size() == DEPTH));
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("ovf", int'(ovf), int'(m_ovf));
`ifdef GPIO_OVF_COUNT_EN
        chk("ovf_count", int'(ovf_count), m_cnt);
`endif
        if (prev_stall) chk("stable", int'(out_data), int'(prev_data));
    endtask

    // Called at a falling edge: apply inputs, advance the model, check after the next rising edge.
    task automatic step(input bit en, input logic [7:0] d, input bit rdy, input bit clr);
        bit pop;
        bit was_full;
        gpio_en   = en;
        gpio_data = d;
        out_ready = rdy;
        ovf_clr   = clr;
        pop       = (q.size() > 0) && rdy;
        was_full  = (q.size() == DEPTH);
        prev_stall = (q.size() > 0) && !rdy;
        prev_data  = out_data;
        if (pop) void'(q.pop_front());
        if (clr) begin
            m_ovf = 0;
            m_cnt = 0;
        end
        if (en) begin
            if (!was_full || pop) begin
                q.push_back(d);
            end else begin
                m_ovf = 1;
                drops++;
                if (m_cnt < 255) m_cnt++;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    logic [7:0] exp_seq [8];

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare_all();
        chk("reset_empty", int'(empty), 1);

        // Reset mid-stream is asynchronous: visible before any clock edge.
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        chk("pre_rst_level", int'(level), 3);
        gpio_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_ovf", int'(ovf), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();

        // Single byte, one cycle latency, popped immediately.
        step(1, 8'hA5, 1, 0);
        chk("single_valid", int'(out_valid), 1);
        chk("single_data", int'(out_data), 8'hA5);
        step(0, 8'h00, 1, 0);
        chk("single_gone", int'(out_valid), 0);
        chk("single_level", int'(level), 0);

        // Burst into a stalled peripheral fills to DEPTH.
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
        chk("burst_level", int'(level), 8);
        chk("burst_full", int'(full), 1);

        // Overflow drops the byte and sets the sticky flag.
        step(1, 8'hFF, 0, 0);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_level", int'(level), 8);
`ifdef GPIO_OVF_COUNT_EN
        chk("ovf_count1", int'(ovf_count), 1);
`endif
        step(0, 8'h00, 0, 1);
        chk("ovf_clr", int'(ovf), 0);

        // Push and pop together while full.
        step(1, 8'h55, 1, 0);
        chk("pp_level", int'(level), 8);
        chk("pp_ovf", int'(ovf), 0);
        exp_seq = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55};
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", int'(out_data), int'(exp_seq[i]));
            step(0, 8'h00, 1, 0);
        end
        chk("drain_empty", int'(empty), 1);

        // Drop and clear in the same cycle keep ovf set.
        for (int i = 0; i < 8; i++) step(1, 8'(8'h80 + i), 0, 0);
        step(1, 8'hEE, 0, 1);
        chk("drop_clr_ovf", int'(ovf), 1);
`ifdef GPIO_OVF_COUNT_EN
        chk("drop_clr_cnt", int'(ovf_count), 1);
`endif

        // Random traffic with phases of differing ready probability.
        for (int c = 0; c < 10000; c++) begin
            int rp;
            rp = ((c / 500) % 3 == 0) ? 20 : (((c / 500) % 3 == 1) ? 90 : 50);
            step($urandom_range(99) < 60, 8'($urandom), $urandom_range(99) < rp, $urandom_range(99) < 2);
        end
        chk("random_saw_drops", int'(drops > 1), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_out_buffer.md
Name: gpio_out_buffer

Overview:
Downstream consumer of the processor's memory-stage GPIO write port: one byte plus a one-cycle enable per store to the GPIO address. It buffers bytes in a DEPTH-entry FIFO and drains them to an external peripheral over a valid/ready handshake. This prevents back-to-back GPIO stores from being lost while a slow peripheral is busy. It also reports occupancy and a sticky overflow flag for status readback.

Parameters:
DATA_W, 8, width of one GPIO byte
DEPTH, 8, total bytes held, output register included; power of 2, >=2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
gpio_data  input  DATA_W  byte from memory controller GPIO port
gpio_en  input  1  push strobe; one byte per asserted cycle
out_data  output  DATA_W  byte presented to peripheral
out_valid  output  1  out_data valid
out_ready  input  1  peripheral accepts out_data this cycle
level  output  $clog2(DEPTH)+1  bytes currently held, 0..DEPTH
full  output  1  level == DEPTH
empty  output  1  level == 0
ovf  output  1  sticky: a push was dropped
ovf_clr  input  1  synchronous clear of ovf

Behaviour:
- Reset (async, active-high) state: FSM IDLE, pointers 0, level 0, out_valid 0, out_data 0, full 0, empty 1, ovf 0. Reset during a transfer discards all stored bytes.
- Structure: circular storage of DEPTH-1 entries plus one registered output slot. All outputs come from registers, with no combinational path from gpio_en or out_ready to any output.
- pop: out_valid && out_ready. push_ok: gpio_en && (!full || pop).
- FSM IDLE: output slot empty, so out_valid=0.
  - On push_ok, the byte loads directly into the output slot and the FSM moves to HOLD.
  - Latency from gpio_en to out_valid is 1 cycle.
- FSM HOLD: out_valid=1, and out_data stays stable until pop.
  - On pop with the FIFO non-empty: the slot loads the FIFO head; if a push happens in the same cycle, that byte enters the FIFO tail. The FSM stays in HOLD.
  - On pop with the FIFO empty and push_ok: the pushed byte loads the slot. The FSM stays in HOLD.
  - On pop with the FIFO empty and no push: the FSM goes to IDLE.
  - With no pop: a push_ok byte goes to the FIFO tail.
- Ordering: strict FIFO. No byte is duplicated or reordered.
- level: +1 on push_ok without pop, -1 on pop without push_ok, otherwise unchanged. full and empty are registered and consistent with level every cycle.
- Full + gpio_en without pop: the byte is dropped, ovf is set, and level stays DEPTH.
- Full + gpio_en with pop: the byte is accepted and level stays DEPTH.
- Pointers wrap modulo DEPTH-1. Pointer width and wrap logic must handle DEPTH=2, where the FIFO has 1 entry.
- ovf_clr has priority below a same-cycle drop: if both occur, ovf stays 1.
- out_ready while out_valid=0 is ignored.

Optional Feature:
GPIO_OVF_COUNT_EN
- Defined: adds output ovf_count (8 bits), incremented on each dropped push and saturating at 255. It is reset to 0 by rst and by ovf_clr. A drop in the same cycle as ovf_clr leaves the count at 1.
- Undefined: the port is absent; only the sticky ovf bit exists.

Decomposition:
- Package gpio_pkg:
  - GPIO_DATA_W=8.
  - GPIO_DEPTH default.
  - FSM state enum gpio_buf_state_t {IDLE, HOLD}.
  - Level-width helper function.
- Sub-module gpio_fifo holds the storage array, read/write pointers and the internal count. It exposes push, pop, head data, empty and full.
- gpio_out_buffer contains the FSM, output slot, level, flags and the optional counter.

Test Plan:
- Reset mid-stream: after pushing 3 bytes, assert rst -> out_valid=0, level=0, empty=1, ovf=0 immediately, without waiting for a clock edge.
- Single byte: gpio_en with 0xA5 at cycle N, out_ready=1 -> out_valid=1 and out_data=0xA5 at N+1; after the pop at N+1, out_valid=0 and level=0 at N+2.
- Burst with stall: push 0x01..0x08 on consecutive cycles with out_ready=0 -> level=8, full=1; then out_ready=1 -> 0x01..0x08 out in order, one per cycle, and empty=1 afterwards.
- Overflow: full at level 8, push 0xFF with out_ready=0 -> byte dropped, ovf=1, level=8, and ovf_count=1 when enabled; assert ovf_clr -> ovf=0.
- Simultaneous push and pop at full: out_ready=1 and gpio_en=0x55 together -> level stays 8, ovf stays 0, and 0x55 emerges last.
- Randomised push/ready traffic for 10k cycles against a scoreboard queue -> no loss except counted drops, exact order, and out_data stable whenever out_valid && !out_ready.
